// File: rtl/icache_pkg.sv
// icache_pkg: shared types for the instruction cache.
//   ITAG_W / IIDX_W : tag and index widths for the default 16-frame cache
//   icachef_t       : fetch address split {tag, idx, bytoff}
//   icache_frame_t  : one cache frame {valid, tag, data}
//   icache_state_t  : fill FSM state {IDLE, FETCH}
//   word_align()    : clears the byte offset of a byte address
package icache_pkg;

  localparam int WORD_W = 32;
  localparam int IIDX_W = 4;
  localparam int ITAG_W = 30 - IIDX_W;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [WORD_W-1:0] data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-port and memory-port signals of the instruction cache.
//   Datapath side : imemREN, imemaddr (in to cache); ihit, imemload (out).
//   Memory side   : iREN, iaddr (out of cache); iwait, iload (in).
//   slave  modport: the cache itself.
//   master modport: the environment driving the cache (datapath + memory).
//
// Handshake: a fetch is requested by holding imemREN high with imemaddr; it is
// served in the cycle where ihit=1. On the memory side a read is requested by
// holding iREN high with iaddr stable, and it completes in the first cycle in
// which iwait=0, when iload carries the data.
interface icache_if;
  import icache_pkg::*;

  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-block, read-only instruction cache.
//   CLK   : clock
//   nRST  : asynchronous active-low reset
//   cif   : icache_if.slave (fetch port + memory read port)
//   state : current fill FSM state (debug visibility)
// Hits are served combinationally from the frame array while IDLE. A miss
// latches the word address into fill_addr and the FSM sits in FETCH until
// memory drops iwait; the frame is written at that edge and the word is then
// served as a hit in the following IDLE cycle.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_if.slave       cif,
  output icache_state_t state
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - IDX_W;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [WORD_W-1:0]   data  [NUM_SETS];

  logic [WORD_W-1:0]   fill_addr;
  logic                iren_q;
  logic [WORD_W-1:0]   iaddr_q;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                lookup_hit;
  logic                fill_done;
  logic                unused_bytoff;

  assign req_idx  = cif.imemaddr[1+IDX_W:2];
  assign req_tag  = cif.imemaddr[WORD_W-1:2+IDX_W];
  assign fill_idx = fill_addr[1+IDX_W:2];
  assign fill_tag = fill_addr[WORD_W-1:2+IDX_W];

  // Byte offset of the fetch address plays no part in the lookup.
  assign unused_bytoff = ^{cif.imemaddr[1:0], fill_addr[1:0]};

  assign lookup_hit = cif.imemREN & valid[req_idx] & (tags[req_idx] == req_tag);
  assign fill_done  = (state == FETCH) & ~cif.iwait;

  // A lookup that matches while a fill is running is not reported: the fetch
  // port only sees hits in IDLE.
  assign cif.ihit     = lookup_hit & (state == IDLE);
  assign cif.imemload = cif.ihit ? data[req_idx] : '0;
  assign cif.iREN     = iren_q;
  assign cif.iaddr    = iaddr_q;

  // Fill FSM with registered memory-side outputs. The async reset also
  // discards any fill in progress, so no frame is written after reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      fill_addr <= '0;
      iren_q    <= 1'b0;
      iaddr_q   <= '0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cif.imemREN && !lookup_hit) begin
            fill_addr <= word_align(cif.imemaddr);
            iaddr_q   <= word_align(cif.imemaddr);
            iren_q    <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // The fill always targets the latched address, whatever the
          // datapath is presenting now.
          if (!cif.iwait) begin
            valid[fill_idx] <= 1'b1;
            iren_q          <= 1'b0;
            iaddr_q         <= '0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage need no reset: valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= cif.iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
`timescale 1ns/1ps
// tb_icache: scoreboard bench for icache. The driver applies one cycle of
// stimulus, predicts that cycle's outputs from a reference model, and queues
// the prediction; a monitor on the falling edge pops and compares.
module tb_icache;
  import icache_pkg::*;

  localparam int NUM_SETS = 16;
  localparam int W = 67; // {fetching, ihit, imemload, iREN, iaddr}

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  icache_state_t state;

  icache_if cif();

  icache #(.NUM_SETS(NUM_SETS)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .cif   (cif),
    .state (state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Memory contents by word number; cache contents as "which word address
  // lives in set s" plus its data.
  logic [31:0] mem       [int];
  logic [31:0] line_addr [int];
  logic [31:0] line_data [int];
  bit          m_fetch = 1'b0;
  logic [31:0] m_fill  = 32'h0;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % NUM_SETS);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  logic [W-1:0] mon_a;
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {state == FETCH, cif.ihit, cif.imemload, cif.iREN, cif.iaddr};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t addr=%h got fetch=%0b ihit=%0b imemload=%h iREN=%0b iaddr=%h want fetch=%0b ihit=%0b imemload=%h iREN=%0b iaddr=%h",
                 $time, cif.imemaddr, mon_a[66], mon_a[65], mon_a[64:33], mon_a[32], mon_a[31:0],
                 mon_e[66], mon_e[65], mon_e[64:33], mon_e[32], mon_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left just after a rising edge.
  task automatic step(input bit ren, input logic [31:0] addr, input bit wait_b);
    bit           hit;
    int           s;
    logic [31:0]  ld;
    logic [W-1:0] e;
    hit = 1'b0;
    ld  = $urandom;
    if (m_fetch && !wait_b) ld = mem_word(m_fill);
    cif.imemREN  = ren;
    cif.imemaddr = addr;
    cif.iwait    = wait_b;
    cif.iload    = ld;
    s = set_of(addr);
    if (m_fetch) begin
      e = {1'b1, 1'b0, 32'h0, 1'b1, m_fill};
    end else begin
      hit = ren && line_addr.exists(s) && (line_addr[s] == align(addr));
      e = {1'b0, hit, (hit ? line_data[s] : 32'h0), 1'b0, 32'h0};
    end
    exp_q.push_back(e);
    @(negedge CLK);
    @(posedge CLK);
    if (m_fetch) begin
      if (!wait_b) begin
        line_addr[set_of(m_fill)] = m_fill;
        line_data[set_of(m_fill)] = ld;
        m_fetch = 1'b0;
      end
    end else if (ren && !hit) begin
      m_fetch = 1'b1;
      m_fill  = align(addr);
    end
    #1;
  endtask

  // Asserts reset, checks the outputs drop at once, clears the model.
  task automatic reset_check(input string name);
    logic [W-1:0] a;
    nRST = 1'b0;
    #1;
    a = {state == FETCH, cif.ihit, cif.imemload, cif.iREN, cif.iaddr};
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s got fetch=%0b ihit=%0b imemload=%h iREN=%0b iaddr=%h want all zero",
               name, a[66], a[65], a[64:33], a[32], a[31:0]);
    end
    line_addr.delete();
    line_data.delete();
    m_fetch = 1'b0;
    m_fill  = 32'h0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    cif.imemREN  = 1'b0;
    cif.imemaddr = 32'h0;
    cif.iwait    = 1'b1;
    cif.iload    = 32'h0;
    mem[0]  = 32'h2001_0004;
    mem[16] = 32'hDEAD_BEEF;

    @(posedge CLK);
    #1;
    reset_check("reset_values");

    // Cold cache with no request: stays idle, nothing on the memory port.
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, 1'($urandom_range(0, 1)));

    // First fill of 0x0 with two wait cycles, then the hit.
    step(1'b1, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b1);
    // Repeat read hits with the memory port idle.
    step(1'b1, 32'h0, 1'b1);

    // Conflict in set 0: 0x40 evicts 0x0, which then misses again.
    step(1'b1, 32'h40, 1'b1);
    step(1'b1, 32'h40, 1'b0);
    step(1'b1, 32'h40, 1'b1);
    step(1'b1, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b1);

    // Address changes mid-fill: 0x10 still fills, then 0x20 misses.
    step(1'b1, 32'h10, 1'b1);
    step(1'b1, 32'h20, 1'b1);
    step(1'b1, 32'h20, 1'b0);
    step(1'b1, 32'h20, 1'b1);
    step(1'b1, 32'h20, 1'b0);
    step(1'b1, 32'h13, 1'b1);
    step(1'b1, 32'h22, 1'b1);

    // Request drops mid-fill: the fill still completes.
    step(1'b1, 32'h30, 1'b1);
    step(1'b0, 32'h0,  1'b1);
    step(1'b0, 32'h0,  1'b0);
    step(1'b1, 32'h30, 1'b0);

    // Reset in the middle of a fill discards it.
    step(1'b1, 32'h84, 1'b1);
    step(1'b1, 32'h84, 1'b1);
    reset_check("reset_mid_fetch");
    step(1'b1, 32'h84, 1'b1);
    step(1'b1, 32'h84, 1'b0);
    step(1'b1, 32'h84, 1'b1);

    // Random traffic over a small address pool so hits, conflicts and
    // tag differences in the high bits all occur.
    for (int i = 0; i < 500; i++) begin
      ra = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra = ra | 32'hA000_0000;
      if ($urandom_range(0, 149) == 0) reset_check("reset_random");
      step($urandom_range(0, 9) < 8, ra, $urandom_range(0, 2) == 0);
    end

    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

- Direct-mapped, one-word-per-block, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port.
- Serves `imemaddr` lookups combinationally on a hit.
- On a miss, runs a single-outstanding-request fill from memory, then serves the word from the array on the following cycle.
- Holds no dirty state; never writes memory.

## Interface

Parameters
- `NUM_SETS`, default 16: number of frames; power of two; index width `IDX_W = log2(NUM_SETS)`.

Ports
- `CLK`  in  1  clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  datapath fetch byte address; bits [1:0] ignored.
- `ihit`  out  1  requested word valid this cycle.
- `imemload`  out  32  instruction word; 0 when `ihit`=0.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address, bits [1:0] always 00.
- `iwait`  in  1  memory busy; fill completes in the first FETCH cycle with `iwait`=0.
- `iload`  in  32  memory read data, valid when `iwait`=0.

## Operation

- Address split: tag = [31:2+IDX_W], idx = [1+IDX_W:2], byte offset = [1:0].
- Frame: valid (1), tag (30-IDX_W), data (32). All frames invalid after reset.
- Hit: `imemREN` & frame[idx].valid & frame[idx].tag == addr tag.
- On a hit, `ihit`=1 and `imemload` = frame[idx].data, combinational, same cycle.
- FSM states: IDLE, FETCH.
- IDLE:
  - `iREN`=0, `iaddr`=0.
  - On `imemREN` & ~hit: latch {imemaddr[31:2],00} into `fill_addr` and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - `iREN`=1, `iaddr`=`fill_addr`, `ihit`=0 regardless of a lookup hit.
  - On `iwait`=0: write frame[fill_addr idx] = {1, fill_addr tag, `iload`} and go to IDLE.
  - On `iwait`=1: stay in FETCH.
- `imemaddr` changes or `imemREN` drops while in FETCH: fill still completes to the latched `fill_addr`. No abort; the new address is looked up in IDLE.
- A fill replaces the frame unconditionally, even if that frame is valid with a different tag.
- No flush or invalidate input; contents persist until reset.

## Timing

- Reset values: state IDLE, all valid=0, `fill_addr`=0, `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- `iREN` falls asynchronously with `nRST`.
- Hit latency: 0 cycles (`ihit` in the same cycle as the request).
- Miss latency: cycle 0 lookup miss (IDLE→FETCH at the edge); cycles 1..N FETCH with `iwait`=1; first cycle with `iwait`=0 writes the frame at the edge; `ihit`=1 the next cycle. With zero memory wait this is 2 cycles of `ihit`=0, then a hit.
- `iREN` stays high continuously from FETCH entry through the completing cycle and is low in the cycle after completion.
- Back-to-back misses: at least one IDLE cycle separates fills.
- Reset mid-FETCH: the fill is discarded, no frame is written, and the FSM is IDLE the cycle after `nRST` rises.

## Structure

- Shared `cpu_types_pkg` additions: `icachef_t` packed struct {tag, idx, bytoff}, `ITAG_W`, `IIDX_W`, `icache_frame_t` {valid, tag, data}, and `icache_state_t` enum {IDLE, FETCH}.
- No sub-module: the frame array, FSM, and `fill_addr` register live in `icache`.
- `icache` connects through the `datapath_cache_if.icache` and `caches_if.icache` modports in the caches wrapper.

## Test plan

- Reset, then `imemREN`=1, `imemaddr`=0x0000_0000, `iwait`=1 for 2 cycles then 0 with `iload`=0x2001_0004:
  - `iREN`=1 for 3 cycles, `iaddr`=0.
  - `ihit`=1 with `imemload`=0x2001_0004 on cycle 4.
- Repeat read of 0x0000_0000: `ihit`=1 same cycle, `iREN` stays 0.
- Conflict: fill 0x0000_0040 (idx 0 with NUM_SETS=16, tag differs) with `iload`=0xDEAD_BEEF, then read 0x0000_0000:
  - The read misses, and `iREN`=1 with `iaddr`=0.
- Change `imemaddr` from 0x10 to 0x20 mid-FETCH:
  - Frame 4 is filled with tag of 0x10.
  - Next IDLE cycle misses on 0x20 and starts a new fill with `iaddr`=0x20.
- Assert `nRST`=0 during FETCH with `iwait`=1:
  - `iREN`=0 immediately.
  - After release, a read of the same address misses.
- `imemREN`=0 with a cold cache: state stays IDLE, `iREN`=0, `ihit`=0.
